// File: rtl/password_pkg.sv
// Shared types and default parameters for the password check sequencer.
package password_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_RESULT,
    ST_LOCKED
  } pw_state_t;

  localparam int DEF_DIGIT_W     = 4;
  localparam int DEF_PASS_LEN    = 4;
  localparam int DEF_MAX_TRIES   = 3;
  localparam int DEF_LOCK_CYCLES = 1024;

endpackage

// File: rtl/pw_lock_timer.sv
// Lockout down-counter: load to LOCK_CYCLES, count down while enabled,
// expire flags the final cycle of the lockout window.
module pw_lock_timer #(
  parameter int LOCK_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int TW = $clog2(LOCK_CYCLES + 1);

  logic [TW-1:0] remaining;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= TW'(LOCK_CYCLES);
    end else if (count && remaining != '0) begin
      remaining <= remaining - TW'(1);
    end
  end

  assign expire = count && (remaining == TW'(1));

endmodule

// File: rtl/password_check_seq.sv
// Password entry/check sequencer with consecutive-failure counting.
// Lockout (LOCKED state + pw_lock_timer) is built only with PASSWORD_CHECK_LOCKOUT_EN.
//
// state     | meaning
// IDLE      | empty entry, waiting for first digit
// ENTRY     | collecting digits
// CHECK     | comparing buffered entry with preset_password
// RESULT    | one-cycle match/fail pulse
// LOCKED    | lockout window after MAX_TRIES consecutive failures
module password_check_seq
  import password_pkg::*;
#(
  parameter int DIGIT_W     = DEF_DIGIT_W,
  parameter int PASS_LEN    = DEF_PASS_LEN,
  parameter int MAX_TRIES   = DEF_MAX_TRIES,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 digit_valid,
  input  logic [DIGIT_W-1:0]                   digit,
  output logic                                 digit_ready,
  input  logic                                 enter,
  input  logic                                 clear,
  input  logic [PASS_LEN*DIGIT_W-1:0]          preset_password,
  output logic                                 match,
  output logic                                 fail,
  output logic                                 locked,
  output logic [$clog2(PASS_LEN+1)-1:0]        entry_cnt,
  output logic [$clog2(MAX_TRIES+1)-1:0]       fail_cnt
);

  localparam int CW = $clog2(PASS_LEN + 1);
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(PASS_LEN);
  localparam logic [FW-1:0] MAX_FAILS = FW'(MAX_TRIES);

  pw_state_t                    state;
  logic [PASS_LEN*DIGIT_W-1:0]  entry_buf;
  logic                         lock_expire;

  assign digit_ready = (state == ST_IDLE) ||
                       ((state == ST_ENTRY) && (entry_cnt < FULL_CNT));

`ifdef PASSWORD_CHECK_LOCKOUT_EN
  logic locked_q;
  logic lock_load;
  logic lock_count;

  assign lock_load  = (state == ST_RESULT) && (fail_cnt == MAX_FAILS);
  assign lock_count = (state == ST_LOCKED);
  assign locked     = locked_q;

  pw_lock_timer #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lock_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (lock_load),
    .count  (lock_count),
    .expire (lock_expire)
  );
`else
  assign locked      = 1'b0;
  assign lock_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      entry_buf <= '0;
      entry_cnt <= '0;
      fail_cnt  <= '0;
      match     <= 1'b0;
      fail      <= 1'b0;
`ifdef PASSWORD_CHECK_LOCKOUT_EN
      locked_q  <= 1'b0;
`endif
    end else begin
      match <= 1'b0;
      fail  <= 1'b0;
      case (state)
        ST_IDLE, ST_ENTRY: begin
          // Priority: clear, then enter, then digit
          if (clear) begin
            entry_buf <= '0;
            entry_cnt <= '0;
            state     <= ST_IDLE;
          end else if (enter) begin
            state <= ST_CHECK;
          end else if (digit_valid && digit_ready) begin
            for (int i = 0; i < PASS_LEN; i++) begin
              if (entry_cnt == CW'(i)) begin
                entry_buf[i*DIGIT_W +: DIGIT_W] <= digit;
              end
            end
            entry_cnt <= entry_cnt + CW'(1);
            state     <= ST_ENTRY;
          end
        end
        ST_CHECK: begin
          if ((entry_cnt == FULL_CNT) && (entry_buf == preset_password)) begin
            match    <= 1'b1;
            fail_cnt <= '0;
          end else begin
            fail <= 1'b1;
            if (fail_cnt != MAX_FAILS) begin
              fail_cnt <= fail_cnt + FW'(1);
            end
          end
          state <= ST_RESULT;
        end
        ST_RESULT: begin
          entry_buf <= '0;
          entry_cnt <= '0;
`ifdef PASSWORD_CHECK_LOCKOUT_EN
          if (fail_cnt == MAX_FAILS) begin
            locked_q <= 1'b1;
            state    <= ST_LOCKED;
          end else begin
            state <= ST_IDLE;
          end
`else
          state <= ST_IDLE;
`endif
        end
        ST_LOCKED: begin
`ifdef PASSWORD_CHECK_LOCKOUT_EN
          if (lock_expire) begin
            locked_q <= 1'b0;
            fail_cnt <= '0;
            state    <= ST_IDLE;
          end
`else
          state <= ST_IDLE;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
